// File: rtl/serializer_tx_sched.sv
// Two-requester round-robin scheduler feeding a PISO serializer.
// Latches the winning byte, issues a load strobe, bit-rate shift strobes, then a frame-done pulse.
module serializer_tx_sched #(
    parameter int DATA_WIDTH = 8,
    parameter int CLK_DIV    = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  s0_valid,
    input  logic [DATA_WIDTH-1:0] s0_data,
    output logic                  s0_ready,
    input  logic                  s1_valid,
    input  logic [DATA_WIDTH-1:0] s1_data,
    output logic                  s1_ready,
    output logic                  ser_load,
    output logic [DATA_WIDTH-1:0] ser_data,
    output logic                  ser_shift,
    output logic                  busy,
    output logic                  grant_id,
    output logic                  frame_done
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int BIT_W = $clog2(DATA_WIDTH + 1);
    localparam logic [DIV_W-1:0] DIV_MAX  = DIV_W'(CLK_DIV - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2,
        GAP   = 2'd3
    } state_t;

    state_t           state;
    logic [DIV_W-1:0] div_cnt;
    logic [DIV_W-1:0] div_next;
    logic [BIT_W-1:0] bit_cnt;
    logic             last_grant;

    logic any_valid;
    logic win;
    logic accept;
    logic div_wrap;
    logic shift_now;
    logic last_shift;

    // Round-robin pick: contention goes to whoever was not granted last.
    assign any_valid  = s0_valid | s1_valid;
    assign win        = (s0_valid & s1_valid) ? ~last_grant : s1_valid;
    assign accept     = (state == IDLE) & ~rst & any_valid;
    assign s0_ready   = accept & ~win;
    assign s1_ready   = accept & win;

    assign div_wrap   = (div_cnt == DIV_MAX);
    assign div_next   = div_wrap ? '0 : div_cnt + DIV_W'(1);
    assign shift_now  = (state == SHIFT) & div_wrap;
    assign last_shift = shift_now & (bit_cnt == BIT_LAST);

    // Frame sequencer; strobes are registered one cycle ahead of the state they belong to.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            div_cnt    <= '0;
            bit_cnt    <= '0;
            last_grant <= 1'b1;
            grant_id   <= 1'b0;
            ser_data   <= '0;
            ser_load   <= 1'b0;
            ser_shift  <= 1'b0;
            frame_done <= 1'b0;
            busy       <= 1'b0;
        end else begin
            ser_load   <= 1'b0;
            ser_shift  <= 1'b0;
            frame_done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        state      <= LOAD;
                        busy       <= 1'b1;
                        grant_id   <= win;
                        last_grant <= win;
                        ser_data   <= win ? s1_data : s0_data;
                        ser_load   <= 1'b1;
                    end
                end
                LOAD: begin
                    state     <= SHIFT;
                    div_cnt   <= '0;
                    bit_cnt   <= '0;
                    ser_shift <= (DIV_MAX == '0);
                end
                SHIFT: begin
                    if (last_shift) begin
                        state      <= GAP;
                        frame_done <= 1'b1;
                    end else begin
                        div_cnt   <= div_next;
                        ser_shift <= (div_next == DIV_MAX);
                        if (shift_now) begin
                            bit_cnt <= bit_cnt + BIT_W'(1);
                        end
                    end
                end
                GAP: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
